// File: rtl/hub75_pkg.sv
// Shared FSM state type, OE polarity constants and pixel slicing helper for hub75_bcm_scanner.
// HUB75_BCM_EN selects full multi-plane BCM in the scanner; otherwise only the MSB plane is shown.
package hub75_pkg;

    typedef enum logic [2:0] {
        WAIT_LINE,
        SHIFT,
        BLANK,
        LATCH,
        SHOW
    } state_t;

    localparam logic OE_ACTIVE = 1'b0;
    localparam logic OE_IDLE   = 1'b1;

    // Widest pixel the slicing helper accepts; narrower pixels are zero-extended.
    localparam int MAX_RGB_RES = 48;
    typedef logic [MAX_RGB_RES-1:0] pixel_t;

    // Pick bit `plane` of each W-bit channel, packed as {R,G,B}.
    function automatic logic [2:0] chan_slice(input pixel_t pixel, input int w, input int plane);
        logic [2:0] s;
        s[2] = |(pixel & (pixel_t'(1) << (2 * w + plane)));
        s[1] = |(pixel & (pixel_t'(1) << (w + plane)));
        s[0] = |(pixel & (pixel_t'(1) << plane));
        return s;
    endfunction

endpackage

// File: rtl/hub75_on_timer.sv
// Loadable down-counter timing the OE-active SHOW window; done is high on the final cycle.
module hub75_on_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 line scanner: requests one line pair per address, shifts it out per BCM plane, sweeps all addresses.
// Build option: define HUB75_BCM_EN for W-plane BCM; without it only the MSB plane is shown.
module hub75_bcm_scanner
    import hub75_pkg::*;
#(
    parameter int NUM_COLS  = 64,
    parameter int SCAN_RATE = 32,
    parameter int RGB_RES   = 9,
    parameter int ON_BASE   = 4
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   slice_start,
    input  logic [1:0][NUM_COLS-1:0][RGB_RES-1:0]  line_data,
    input  logic                                   tvalid,
    output logic                                   tready,
    output logic [$clog2(SCAN_RATE)-1:0]           req_addr,
    output logic [$clog2(SCAN_RATE)-1:0]           hub75_addr,
    output logic [2:0]                             hub75_rgb0,
    output logic [2:0]                             hub75_rgb1,
    output logic                                   hub75_clk,
    output logic                                   hub75_latch,
    output logic                                   hub75_OE,
    output logic                                   sweep_done,
    output state_t                                 fsm_state
);

    localparam int W  = RGB_RES / 3;
    localparam int AW = $clog2(SCAN_RATE);
    localparam int CW = $clog2(NUM_COLS) + 1;
    localparam int XW = CW - 1;
    localparam int TW = $clog2(ON_BASE << (W - 1)) + 1;

    state_t                                 state_q, state_d;
    logic [CW-1:0]                          col_q, col_d;
    logic [AW-1:0]                          addr_d;
    logic [XW-1:0]                          col_idx;
    logic [RGB_RES-1:0]                     pix0, pix1;
    logic [1:0][NUM_COLS-1:0][RGB_RES-1:0]  line_q;
    logic                                   capture, wrap, tmr_load, tmr_done, last_plane;
    logic [TW-1:0]                          on_len;
    int                                     rgb_plane;

`ifdef HUB75_BCM_EN
    localparam int PW = (W > 1) ? $clog2(W) : 1;
    logic [PW-1:0] plane_q, plane_d;

    // Plane rests at 0 whenever idle, so an accept always starts from the LSB plane.
    always_comb begin
        plane_d = plane_q;
        if (state_d == WAIT_LINE) begin
            plane_d = '0;
        end else if (state_q == SHOW && state_d == SHIFT) begin
            plane_d = plane_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) plane_q <= '0;
        else        plane_q <= plane_d;
    end

    assign last_plane = (plane_q == PW'(W - 1));
    assign on_len     = TW'(ON_BASE) << plane_q;
    assign rgb_plane  = int'(plane_d);
`else
    assign last_plane = 1'b1;
    assign on_len     = TW'(ON_BASE);
    assign rgb_plane  = W - 1;
`endif

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        addr_d   = req_addr;
        capture  = 1'b0;
        wrap     = 1'b0;
        tmr_load = 1'b0;
        if (slice_start) begin
            state_d = WAIT_LINE;
            col_d   = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                WAIT_LINE: begin
                    if (tvalid && tready) begin
                        capture = 1'b1;
                        state_d = SHIFT;
                        col_d   = '0;
                    end
                end
                SHIFT: begin
                    if (col_q == CW'(2 * NUM_COLS - 1)) state_d = BLANK;
                    else                                col_d   = col_q + 1'b1;
                end
                BLANK: state_d = LATCH;
                LATCH: begin
                    state_d  = SHOW;
                    tmr_load = 1'b1;
                end
                SHOW: begin
                    if (tmr_done) begin
                        if (!last_plane) begin
                            state_d = SHIFT;
                            col_d   = '0;
                        end else begin
                            state_d = WAIT_LINE;
                            if (req_addr == AW'(SCAN_RATE - 1)) begin
                                addr_d = '0;
                                wrap   = 1'b1;
                            end else begin
                                addr_d = req_addr + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = WAIT_LINE;
            endcase
        end
    end

    // On the accepting edge the line is not yet captured, so column 0 comes straight from the input.
    assign col_idx = col_d[CW-1:1];
    assign pix0    = (state_q == WAIT_LINE) ? line_data[0][col_idx] : line_q[0][col_idx];
    assign pix1    = (state_q == WAIT_LINE) ? line_data[1][col_idx] : line_q[1][col_idx];

    hub75_on_timer #(.WIDTH(TW)) u_on_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load       (tmr_load),
        .load_value (on_len),
        .done       (tmr_done)
    );

    always_ff @(posedge clk_in) begin
        if (capture) line_q <= line_data;
    end

    // Outputs are registered from the next-state values so they line up with the state they belong to.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= WAIT_LINE;
            col_q       <= '0;
            req_addr    <= '0;
            hub75_addr  <= '0;
            hub75_rgb0  <= '0;
            hub75_rgb1  <= '0;
            hub75_clk   <= 1'b0;
            hub75_latch <= 1'b0;
            hub75_OE    <= OE_IDLE;
            tready      <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            req_addr    <= addr_d;
            tready      <= (state_d == WAIT_LINE);
            hub75_clk   <= (state_d == SHIFT) && col_d[0];
            hub75_latch <= (state_d == LATCH);
            hub75_OE    <= (state_d == SHOW) ? OE_ACTIVE : OE_IDLE;
            sweep_done  <= wrap;
            if (state_d == BLANK) hub75_addr <= req_addr;
            if (state_d == SHIFT && !col_d[0]) begin
                hub75_rgb0 <= chan_slice(pixel_t'(pix0), W, rgb_plane);
                hub75_rgb1 <= chan_slice(pixel_t'(pix1), W, rgb_plane);
            end
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Self-checking bench for hub75_bcm_scanner with a trace-level reference model of one line's output.
module tb_hub75_bcm_scanner;
    import hub75_pkg::*;

    localparam int NUM_COLS  = 4;
    localparam int SCAN_RATE = 2;
    localparam int RGB_RES   = 6;
    localparam int ON_BASE   = 2;
    localparam int W         = RGB_RES / 3;
    localparam int AW        = $clog2(SCAN_RATE);
`ifdef HUB75_BCM_EN
    localparam int FIRST_PLANE = 0;
`else
    localparam int FIRST_PLANE = W - 1;
`endif

    logic                                  clk_in;
    logic                                  rst_in;
    logic                                  slice_start;
    logic [1:0][NUM_COLS-1:0][RGB_RES-1:0] line_data;
    logic                                  tvalid;
    logic                                  tready;
    logic [AW-1:0]                         req_addr;
    logic [AW-1:0]                         hub75_addr;
    logic [2:0]                            hub75_rgb0;
    logic [2:0]                            hub75_rgb1;
    logic                                  hub75_clk;
    logic                                  hub75_latch;
    logic                                  hub75_OE;
    logic                                  sweep_done;
    state_t                                fsm_state;

    hub75_bcm_scanner #(
        .NUM_COLS  (NUM_COLS),
        .SCAN_RATE (SCAN_RATE),
        .RGB_RES   (RGB_RES),
        .ON_BASE   (ON_BASE)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .slice_start (slice_start),
        .line_data   (line_data),
        .tvalid      (tvalid),
        .tready      (tready),
        .req_addr    (req_addr),
        .hub75_addr  (hub75_addr),
        .hub75_rgb0  (hub75_rgb0),
        .hub75_rgb1  (hub75_rgb1),
        .hub75_clk   (hub75_clk),
        .hub75_latch (hub75_latch),
        .hub75_OE    (hub75_OE),
        .sweep_done  (sweep_done),
        .fsm_state   (fsm_state)
    );

    // Clock and watchdog
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One expected output cycle of a line's display sequence
    typedef struct {
        logic [2:0] rgb0;
        logic [2:0] rgb1;
        logic       clk;
        logic       latch;
        logic       oe;
        logic       tready;
        logic       chk_rgb;
        logic       chk_addr;
    } exp_t;

    exp_t exp_q[$];
    int   m_top[NUM_COLS];
    int   m_bot[NUM_COLS];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    // Reference model: OE-on length and channel bits straight from the pixel format rules
    function automatic int on_cycles(input int p);
`ifdef HUB75_BCM_EN
        return ON_BASE * (1 << p);
`else
        return ON_BASE + 0 * p;
`endif
    endfunction

    function automatic int addr_period();
        int total = 1;
        for (int p = FIRST_PLANE; p < W; p++) total += 2 * NUM_COLS + 2 + on_cycles(p);
        return total;
    endfunction

    function automatic logic [2:0] plane_bits(input int pix, input int p);
        int r = pix / (1 << (2 * W));
        int g = (pix / (1 << W)) % (1 << W);
        int b = pix % (1 << W);
        logic [2:0] v;
        v[2] = r[p];
        v[1] = g[p];
        v[0] = b[p];
        return v;
    endfunction

    function automatic exp_t mk(input logic [2:0] a, input logic [2:0] b, input logic c,
                                input logic l, input logic o, input logic t,
                                input logic cr, input logic ca);
        exp_t e;
        e.rgb0 = a; e.rgb1 = b; e.clk = c; e.latch = l;
        e.oe = o; e.tready = t; e.chk_rgb = cr; e.chk_addr = ca;
        return e;
    endfunction

    task automatic build_trace();
        exp_q.delete();
        for (int p = FIRST_PLANE; p < W; p++) begin
            for (int k = 0; k < 2 * NUM_COLS; k++)
                exp_q.push_back(mk(plane_bits(m_top[k / 2], p), plane_bits(m_bot[k / 2], p),
                                   logic'(k % 2), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
            exp_q.push_back(mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
            for (int s = 0; s < on_cycles(p); s++)
                exp_q.push_back(mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        exp_q.push_back(mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    endtask

    // Driver tasks
    task automatic new_line(input int top_fixed);
        for (int c = 0; c < NUM_COLS; c++) begin
            m_top[c] = (top_fixed >= 0) ? top_fixed : int'($urandom_range(0, 63));
            m_bot[c] = int'($urandom_range(0, 63));
        end
    endtask

    task automatic drive_line();
        for (int c = 0; c < NUM_COLS; c++) begin
            line_data[0][c] = RGB_RES'(m_top[c]);
            line_data[1][c] = RGB_RES'(m_bot[c]);
        end
    endtask

    // Accept the model line for `addr`, then compare all but the last `trim` expected cycles.
    task automatic play(input int addr, input bit keep, input int trim, input bit wrap);
        int n = 0;
        int lim;
        while (tready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("acc_tready", tready, 1);
        check("acc_req_addr", req_addr, addr);
        drive_line();
        tvalid = 1'b1;
        build_trace();
        lim = exp_q.size() - trim;
        step();
        if (!keep) tvalid = 1'b0;
        for (int i = 0; i < lim; i++) begin
            check("clk", hub75_clk, exp_q[i].clk);
            check("latch", hub75_latch, exp_q[i].latch);
            check("oe", hub75_OE, exp_q[i].oe);
            check("tready", tready, exp_q[i].tready);
            check("sweep_done", sweep_done, (i == exp_q.size() - 1) ? wrap : 1'b0);
            if (exp_q[i].chk_rgb) begin
                check("rgb0", hub75_rgb0, exp_q[i].rgb0);
                check("rgb1", hub75_rgb1, exp_q[i].rgb1);
            end
            if (exp_q[i].chk_addr) check("hub75_addr", hub75_addr, addr);
            if (i < lim - 1) step();
        end
    endtask

    initial begin
        rst_in      = 1'b1;
        slice_start = 1'b0;
        tvalid      = 1'b0;
        line_data   = '0;

        // Reset state
        repeat (3) step();
        check("rst_oe", hub75_OE, 1);
        check("rst_clk", hub75_clk, 0);
        check("rst_latch", hub75_latch, 0);
        check("rst_tready", tready, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_hub75_addr", hub75_addr, 0);
        check("rst_rgb0", hub75_rgb0, 0);
        check("rst_rgb1", hub75_rgb1, 0);
        check("rst_sweep_done", sweep_done, 0);
        rst_in = 1'b0;
        step();
        check("rel_tready", tready, 1);

        // Directed line 6'b11_01_10 with tvalid held, then a random line for address 1 closes the sweep
        new_line(6'b110110);
        acc_cyc = cyc;
        play(0, 1'b1, 0, 1'b0);
        check("addr_inc", req_addr, 1);
        new_line(-1);
        play(1, 1'b0, 0, 1'b1);
        check("addr_wrap", req_addr, 0);
        check("sweep_latency", cyc - acc_cyc, 2 * addr_period());
        step();
        check("sweep_pulse_width", sweep_done, 0);

        // Stall after address 0: panel dark, request held at 1
        new_line(-1);
        play(0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_tready", tready, 1);
            check("stall_oe", hub75_OE, 1);
            check("stall_clk", hub75_clk, 0);
            check("stall_latch", hub75_latch, 0);
            check("stall_req_addr", req_addr, 1);
            check("stall_state", fsm_state, WAIT_LINE);
        end

        // slice_start on the first cycle of the last plane's SHOW
        new_line(-1);
        play(1, 1'b0, on_cycles(W - 1), 1'b0);
        slice_start = 1'b1;
        step();
        slice_start = 1'b0;
        check("slice_oe", hub75_OE, 1);
        check("slice_req_addr", req_addr, 0);
        check("slice_tready", tready, 1);
        check("slice_clk", hub75_clk, 0);
        check("slice_latch", hub75_latch, 0);
        for (int i = 0; i < 5; i++) begin
            check("slice_no_sweep", sweep_done, 0);
            step();
        end

        // slice_start coincident with a handshake: nothing captured
        new_line(-1);
        drive_line();
        tvalid      = 1'b1;
        slice_start = 1'b1;
        step();
        slice_start = 1'b0;
        tvalid      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("coinc_tready", tready, 1);
            check("coinc_oe", hub75_OE, 1);
            check("coinc_clk", hub75_clk, 0);
            check("coinc_req_addr", req_addr, 0);
            step();
        end

        // Normal operation resumes from address 0
        new_line(-1);
        play(0, 1'b0, 0, 1'b0);
        check("resume_addr", req_addr, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
